ps2_direction_decoder: RTL and testbench

PS/2 keyboard receiver and key-state decoder. It produces the 4-bit held-direction vector consumed by the object position shifter: bit0 Up, bit1 Down, bit2 Left, bit3 Right.
- Receives device-to-host PS/2 frames.
- Validates framing and parity.
- Tracks E0/F0 prefixes.
- Holds one bit per direction key while that key is pressed.

It sits between the board PS/2 pins and the object motion logic, in the VGA pixel clock domain.

---
 rtl/ps2_direction_decoder_if.sv | 29 ++
 rtl/ps2_direction_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_direction_decoder_if.sv
// PS/2 direction decoder bus: raw PS/2 pins in, decoded key state out.
// The master modport belongs to whatever drives the PS/2 pins and watches
// the results. The slave modport belongs to the decoder.
interface ps2_direction_decoder_if;
  logic       PS2Clock;
  logic       PS2Data;
  logic [3:0] Direction;
  logic [7:0] ScanCode;
  logic       CodeValid;
  logic       FrameError;

  modport master (
    output PS2Clock,
    output PS2Data,
    input  Direction,
    input  ScanCode,
    input  CodeValid,
    input  FrameError
  );

  modport slave (
    input  PS2Clock,
    input  PS2Data,
    output Direction,
    output ScanCode,
    output CodeValid,
    output FrameError
  );
endinterface

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver and arrow-key state decoder.
// Direction bits: bit0 Up, bit1 Down, bit2 Left, bit3 Right.
// Optional build macro PS2_WASD_EN adds W/A/S/D as aliases of the arrow keys
// in the non-extended map.
module ps2_direction_decoder #(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SYNC_STAGES    = 2
) (
  input logic                    Clock,
  input logic                    Reset,
  ps2_direction_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  // Key lookup: returns {hit, one-hot direction mask}.
  function automatic logic [4:0] lookup(input logic [7:0] code, input logic ext);
    logic [4:0] r;
    r = 5'b0_0000;
    if (ext) begin
      case (code)
        8'h75:   r = 5'b1_0001;
        8'h72:   r = 5'b1_0010;
        8'h6B:   r = 5'b1_0100;
        8'h74:   r = 5'b1_1000;
        default: r = 5'b0_0000;
      endcase
    end else begin
`ifdef PS2_WASD_EN
      case (code)
        8'h1D:   r = 5'b1_0001;
        8'h1B:   r = 5'b1_0010;
        8'h1C:   r = 5'b1_0100;
        8'h23:   r = 5'b1_1000;
        default: r = 5'b0_0000;
      endcase
`else
      r = 5'b0_0000;
`endif
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          timeout_q, timeout_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [3:0]             direction_q, direction_d;
  logic [7:0]             scan_q, scan_d;
  logic                   cv_q, cv_d;
  logic                   fe_q, fe_d;

  logic                   clk_cur_s;
  logic                   data_s;
  logic                   fall_s;
  logic                   in_frame_s;
  logic [4:0]             hit_s;

  assign clk_cur_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s     = data_sync_q[SYNC_STAGES-1];
  assign fall_s     = clk_prev_q & ~clk_cur_s;
  assign in_frame_s = (state_q == ST_DATA) || (state_q == ST_PARITY) ||
                      (state_q == ST_STOP);
  assign hit_s      = lookup(shift_q, ext_q);

  // Shift the raw pins through the synchroniser and keep the previous clock level.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.PS2Clock};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.PS2Data};
    clk_prev_d  = clk_cur_s;
  end

  // Frame receiver, timeout, prefix tracking and direction decode.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    timeout_d   = timeout_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    direction_d = direction_q;
    scan_d      = scan_q;
    cv_d        = 1'b0;
    fe_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timeout_d = '0;
        if (fall_s && !data_s) begin
          state_d  = ST_DATA;
          bitcnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          timeout_d = '0;
          shift_d   = {data_s, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          timeout_d = '0;
          parity_d  = data_s;
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          // Outputs register on this edge so CodeValid is seen during CHECK.
          timeout_d = '0;
          state_d   = ST_CHECK;
          if (data_s && (^{shift_q, parity_q})) begin
            scan_d = shift_q;
            cv_d   = 1'b1;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              if (hit_s[4]) begin
                if (brk_q) begin
                  direction_d = direction_q & ~hit_s[3:0];
                end else begin
                  direction_d = direction_q | hit_s[3:0];
                end
              end else begin
                direction_d = direction_q;
              end
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            fe_d  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_CHECK: begin
        timeout_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        timeout_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    // A stalled frame is abandoned; the decoded key state is left alone.
    if (in_frame_s && !fall_s) begin
      if (timeout_q == TO_LAST) begin
        state_d   = ST_IDLE;
        timeout_d = '0;
        fe_d      = 1'b1;
      end else begin
        timeout_d = timeout_q + TW'(1);
      end
    end else begin
      timeout_d = timeout_d;
    end
  end

  // State registers; the synchroniser presets to the idle-high pin level.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      timeout_q   <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      direction_q <= 4'b0000;
      scan_q      <= 8'h00;
      cv_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      timeout_q   <= timeout_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      direction_q <= direction_d;
      scan_q      <= scan_d;
      cv_q        <= cv_d;
      fe_q        <= fe_d;
    end
  end

  assign bus.Direction  = direction_q;
  assign bus.ScanCode   = scan_q;
  assign bus.CodeValid  = cv_q;
  assign bus.FrameError = fe_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed testbench for ps2_direction_decoder (TIMEOUT_CYCLES=50).
module tb_ps2_direction_decoder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cv_cnt;
  int   fe_cnt;

  ps2_direction_decoder_if bus ();

  ps2_direction_decoder #(.TIMEOUT_CYCLES(50), .SYNC_STAGES(2)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles during which each pulse output is high.
  always @(posedge clk) begin
    if (bus.CodeValid) cv_cnt = cv_cnt + 1;
    if (bus.FrameError) fe_cnt = fe_cnt + 1;
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.PS2Data = b;
    repeat (5) @(negedge clk);
    bus.PS2Clock = 1'b0;
    repeat (5) @(negedge clk);
    bus.PS2Clock = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic p;
    p = bad ? (^b) : ~(^b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.Direction !== 4'b0000 || bus.ScanCode !== 8'h00 ||
        bus.CodeValid !== 1'b0 || bus.FrameError !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dir=%b sc=%h cv=%b fe=%b want 0000 00 0 0",
               bus.Direction, bus.ScanCode, bus.CodeValid, bus.FrameError);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ext_make();
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    checks++;
    if (cv_cnt - cv0 !== 2) begin
      errors++; $display("FAIL ext_make cv_pulses: got %0d want 2", cv_cnt - cv0);
    end
    checks++;
    if (fe_cnt - fe0 !== 0) begin
      errors++; $display("FAIL ext_make fe_pulses: got %0d want 0", fe_cnt - fe0);
    end
    checks++;
    if (bus.ScanCode !== 8'h75) begin
      errors++; $display("FAIL ext_make scancode: got %h want 75", bus.ScanCode);
    end
    checks++;
    if (bus.Direction !== 4'b0001) begin
      errors++; $display("FAIL ext_make dir: got %b want 0001", bus.Direction);
    end
  endtask

  task automatic test_ext_break();
    int cv0;
    cv0 = cv_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    checks++;
    if (cv_cnt - cv0 !== 3) begin
      errors++; $display("FAIL ext_break cv_pulses: got %0d want 3", cv_cnt - cv0);
    end
    checks++;
    if (bus.Direction !== 4'b0000 || bus.ScanCode !== 8'h75) begin
      errors++; $display("FAIL ext_break: got dir=%b sc=%h want 0000 75", bus.Direction, bus.ScanCode);
    end
  endtask

  task automatic test_multi_keys();
    send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
    checks++;
    if (bus.Direction !== 4'b1100) begin
      errors++; $display("FAIL multi_make dir: got %b want 1100", bus.Direction);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h6B, 1'b0);
    checks++;
    if (bus.Direction !== 4'b1000 || bus.ScanCode !== 8'h6B) begin
      errors++; $display("FAIL multi_break: got dir=%b sc=%h want 1000 6b", bus.Direction, bus.ScanCode);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h74, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    checks++;
    if (bus.Direction !== 4'b0001) begin
      errors++; $display("FAIL typematic dir: got %b want 0001", bus.Direction);
    end
  endtask

  task automatic test_parity_error();
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_byte(8'h75, 1'b1);
    checks++;
    if (fe_cnt - fe0 !== 1 || cv_cnt - cv0 !== 0) begin
      errors++; $display("FAIL parity_err pulses: got fe=%0d cv=%0d want 1 0", fe_cnt - fe0, cv_cnt - cv0);
    end
    checks++;
    if (bus.Direction !== 4'b0001 || bus.ScanCode !== 8'h75) begin
      errors++; $display("FAIL parity_err hold: got dir=%b sc=%h want 0001 75", bus.Direction, bus.ScanCode);
    end
    send_byte(8'h6B, 1'b1);
    checks++;
    if (bus.ScanCode !== 8'h75) begin
      errors++; $display("FAIL parity_err scancode: got %h want 75", bus.ScanCode);
    end
    // E0 prefix must be dropped by the bad frame, so 72 is the keypad code.
    send_byte(8'hE0, 1'b0);
    send_byte(8'h72, 1'b1);
    send_byte(8'h72, 1'b0);
    checks++;
    if (bus.Direction !== 4'b0001 || bus.ScanCode !== 8'h72) begin
      errors++; $display("FAIL parity_err prefix_clear: got dir=%b sc=%h want 0001 72", bus.Direction, bus.ScanCode);
    end
  endtask

  task automatic test_timeout();
    int fe0, first;
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    fe0 = fe_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    bus.PS2Data = 1'b0;
    repeat (5) @(negedge clk);
    bus.PS2Clock = 1'b0;
    first = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 5) bus.PS2Clock = 1'b1;
      if (cyc == 5) bus.PS2Data = 1'b1;
      if (bus.FrameError && first < 0) first = cyc;
    end
    checks++;
    if (first < 48 || first > 58) begin
      errors++; $display("FAIL timeout_cycle: got %0d want 48..58", first);
    end
    checks++;
    if (fe_cnt - fe0 !== 1 || bus.Direction !== 4'b0000) begin
      errors++; $display("FAIL timeout_pulse: got fe=%0d dir=%b want 1 0000", fe_cnt - fe0, bus.Direction);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    checks++;
    if (bus.Direction !== 4'b0010) begin
      errors++; $display("FAIL timeout_recover dir: got %b want 0010", bus.Direction);
    end
  endtask

  task automatic test_nonext();
    int cv0;
    cv0 = cv_cnt;
    send_byte(8'h75, 1'b0);
    checks++;
    if (cv_cnt - cv0 !== 1 || bus.Direction !== 4'b0010 || bus.ScanCode !== 8'h75) begin
      errors++; $display("FAIL keypad_75: got cv=%0d dir=%b sc=%h want 1 0010 75", cv_cnt - cv0, bus.Direction, bus.ScanCode);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h6B, 1'b0);
    checks++;
    if (bus.Direction !== 4'b0010) begin
      errors++; $display("FAIL break_unheld dir: got %b want 0010", bus.Direction);
    end
    send_byte(8'h1D, 1'b0);
`ifdef PS2_WASD_EN
    checks++;
    if (bus.Direction !== 4'b0011) begin
      errors++; $display("FAIL wasd_make dir: got %b want 0011", bus.Direction);
    end
`else
    checks++;
    if (bus.Direction !== 4'b0010 || bus.ScanCode !== 8'h1D) begin
      errors++; $display("FAIL wasd_off: got dir=%b sc=%h want 0010 1d", bus.Direction, bus.ScanCode);
    end
`endif
    send_byte(8'hF0, 1'b0); send_byte(8'h1D, 1'b0);
    checks++;
    if (bus.Direction !== 4'b0010) begin
      errors++; $display("FAIL wasd_break dir: got %b want 0010", bus.Direction);
    end
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.Direction !== 4'b0000 || bus.ScanCode !== 8'h00 ||
        bus.CodeValid !== 1'b0 || bus.FrameError !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: got dir=%b sc=%h cv=%b fe=%b want 0000 00 0 0",
               bus.Direction, bus.ScanCode, bus.CodeValid, bus.FrameError);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h72, 1'b0);
    checks++;
    if (bus.Direction !== 4'b0000 || bus.ScanCode !== 8'h72) begin
      errors++; $display("FAIL after_reset 72: got dir=%b sc=%h want 0000 72", bus.Direction, bus.ScanCode);
    end
  endtask

  initial begin
    errors = 0; checks = 0; cv_cnt = 0; fe_cnt = 0;
    rst = 1'b1;
    bus.PS2Clock = 1'b1;
    bus.PS2Data  = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_ext_make();
    test_ext_break();
    test_multi_keys();
    test_parity_error();
    test_timeout();
    test_nonext();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
